// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline types and constants for the data-memory access controller
package riscv_pipe_pkg;
    localparam int XLEN = 32;
    localparam logic DM_EN_ACTIVE = 1'b0;
    localparam logic DM_WR_ACTIVE = 1'b0;
    typedef enum logic [1:0] {DMC_IDLE, DMC_WAIT, DMC_DONE, DMC_ERR} dmc_state_e;
endpackage

// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if: req/ack data-memory port between the access controller and the memory
interface dm_access_ctrl_if #(parameter int XLEN = riscv_pipe_pkg::XLEN);
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;
    modport master(output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, input mem_ack_i, mem_rdata_i);
    modport slave(input mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, output mem_ack_i, mem_rdata_i);
endinterface

// File: rtl/dmc_timeout_cnt.sv
// dmc_timeout_cnt: counts cycles spent waiting for an ack and flags the last allowed cycle
module dmc_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TO_W-1:0] cnt;
    always_ff @(posedge clk)
        if (!rst_n || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign expired = cnt == TO_W'(TIMEOUT - 1);
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences EX/MEM data-memory accesses over a req/ack port, stalling the pipeline
// until completion and flagging misaligned or timed-out accesses
module dm_access_ctrl #(
    parameter int XLEN    = riscv_pipe_pkg::XLEN,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dm_enable_n_i,
    input  logic            dm_wen_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    dm_access_ctrl_if.master bus,
    output logic            stall_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            rdata_valid_o,
    output logic            bus_err_o
);
    import riscv_pipe_pkg::*;
    dmc_state_e state, state_d;
    logic op, misaligned, expired;
    assign op         = dm_enable_n_i == DM_EN_ACTIVE;
    assign misaligned = addr_i[1:0] != 2'b00;
    dmc_timeout_cnt #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
        .clk,
        .rst_n,
        .clr(state != DMC_WAIT),
        .en(state == DMC_WAIT),
        .expired
    );
    always_ff @(posedge clk) state <= !rst_n ? DMC_IDLE : state_d;
    // DONE/ERR always fall back to IDLE so a still-visible op never re-triggers
    always_comb begin
        state_d = state;
        case (state)
            DMC_IDLE: state_d = !op ? DMC_IDLE : misaligned ? DMC_ERR : DMC_WAIT;
            DMC_WAIT: state_d = bus.mem_ack_i ? DMC_DONE : expired ? DMC_ERR : DMC_WAIT;
            default:  state_d = DMC_IDLE;
        endcase
    end
    always_comb begin
        stall_o       = rst_n && (state == DMC_WAIT || (state == DMC_IDLE && op));
        bus.mem_req_o = state == DMC_WAIT;
        bus_err_o     = state == DMC_ERR;
        rdata_valid_o = state == DMC_DONE && !bus.mem_we_o;
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.mem_we_o    <= 1'b0;
            rdata_o         <= '0;
        end else begin
            if (state == DMC_IDLE && op && !misaligned) begin
                bus.mem_addr_o  <= addr_i;
                bus.mem_wdata_o <= wdata_i;
                bus.mem_we_o    <= dm_wen_i == DM_WR_ACTIVE;
            end
            if (state == DMC_WAIT && bus.mem_ack_i) rdata_o <= bus.mem_we_o ? '0 : bus.mem_rdata_i;
            else if (state_d == DMC_ERR) rdata_o <= '0;
        end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed and randomized transaction-level checks of dm_access_ctrl
module tb_dm_access_ctrl;
    localparam int TO = 16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dm_enable_n_i = 1'b1;
    logic        dm_wen_i = 1'b1;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        stall_o, rdata_valid_o, bus_err_o;
    logic [31:0] rdata_o;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = '0;

    dm_access_ctrl_if #(.XLEN(32)) bus();

    dm_access_ctrl #(.XLEN(32), .TIMEOUT(TO), .TO_W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dm_enable_n_i(dm_enable_n_i),
        .dm_wen_i(dm_wen_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .bus(bus),
        .stall_o(stall_o),
        .rdata_o(rdata_o),
        .rdata_valid_o(rdata_valid_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc_check(input string ph, input bit req, input bit stall, input bit err, input bit vld);
        chk({ph, ".req"}, 32'(bus.mem_req_o), 32'(req));
        chk({ph, ".stall"}, 32'(stall_o), 32'(stall));
        chk({ph, ".err"}, 32'(bus_err_o), 32'(err));
        chk({ph, ".valid"}, 32'(rdata_valid_o), 32'(vld));
        chk({ph, ".rdata"}, rdata_o, exp_rdata);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One memory op: k = cycle of req in which ack arrives; k > TO means no ack at all
    task automatic run_op(input bit load, input logic [31:0] a, input logic [31:0] wd, input int k,
                          input logic [31:0] rd, input int idle_after, input bit spur);
        int n;
        dm_enable_n_i = 1'b0;
        dm_wen_i = load;
        addr_i = a;
        wdata_i = wd;
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = $urandom;
        @(negedge clk);
        cyc_check("issue", 0, 1, 0, 0);
        next_cycle();
        if (a[1:0] != 2'b00) begin
            bus.mem_ack_i = spur;
            exp_rdata = '0;
            @(negedge clk);
            cyc_check("misalign", 0, 0, 1, 0);
            next_cycle();
        end else begin
            n = (k > TO) ? TO : k;
            for (int i = 1; i <= n; i++) begin
                bus.mem_ack_i = (i == k);
                bus.mem_rdata_i = (i == k) ? rd : $urandom;
                @(negedge clk);
                cyc_check("wait", 1, 1, 0, 0);
                chk("wait.we", 32'(bus.mem_we_o), 32'(!load));
                chk("wait.addr", bus.mem_addr_o, a);
                chk("wait.wdata", bus.mem_wdata_o, wd);
                next_cycle();
            end
            bus.mem_ack_i = spur;
            bus.mem_rdata_i = $urandom;
            if (k <= TO) begin
                exp_rdata = load ? rd : 32'h0;
                @(negedge clk);
                cyc_check("done", 0, 0, 0, load);
            end else begin
                exp_rdata = '0;
                @(negedge clk);
                cyc_check("timeout", 0, 0, 1, 0);
            end
            next_cycle();
        end
        for (int j = 0; j < idle_after; j++) begin
            dm_enable_n_i = 1'b1;
            bus.mem_ack_i = 1'($urandom);
            addr_i = $urandom;
            @(negedge clk);
            cyc_check("idle", 0, 0, 0, 0);
            next_cycle();
        end
    endtask

    initial begin
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = '0;
        dm_enable_n_i = 1'b0;
        addr_i = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        cyc_check("reset", 0, 0, 0, 0);
        chk("reset.we", 32'(bus.mem_we_o), 32'h0);
        chk("reset.addr", bus.mem_addr_o, 32'h0);
        chk("reset.wdata", bus.mem_wdata_o, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        dm_enable_n_i = 1'b1;
        @(negedge clk);
        cyc_check("idle0", 0, 0, 0, 0);
        next_cycle();

        run_op(1, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1, 0);
        run_op(0, 32'h0000_0020, 32'h1234_5678, 3, 32'hFFFF_FFFF, 1, 1);
        run_op(1, 32'h0000_0013, 32'h0, 1, 32'h0, 1, 1);
        run_op(1, 32'h0000_0044, 32'h0, TO + 1, 32'h0, 1, 0);
        run_op(1, 32'h0000_0048, 32'h0, TO, 32'hCAFE_F00D, 1, 0);
        run_op(1, 32'h0000_0100, 32'h0, 1, 32'h1111_2222, 0, 0);
        run_op(0, 32'h0000_0104, 32'hA5A5_5A5A, 1, 32'h3333_4444, 1, 0);

        // reset in the middle of a WAIT
        dm_enable_n_i = 1'b0;
        dm_wen_i = 1'b1;
        addr_i = 32'h200;
        @(negedge clk);
        cyc_check("rst.issue", 0, 1, 0, 0);
        next_cycle();
        @(negedge clk);
        cyc_check("rst.wait", 1, 1, 0, 0);
        next_cycle();
        rst_n = 1'b0;
        dm_enable_n_i = 1'b1;
        @(negedge clk);
        chk("rst.stall_forced", 32'(stall_o), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = 32'h9999_9999;
        exp_rdata = '0;
        @(negedge clk);
        cyc_check("rst.after", 0, 0, 0, 0);
        next_cycle();
        run_op(1, 32'h0000_0204, 32'h0, 2, 32'h7777_8888, 1, 0);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            run_op(1'($urandom), a, $urandom, int'($urandom_range(TO + 4, 1)), $urandom,
                   int'($urandom_range(2)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequences data-memory accesses issued from the EX/MEM pipeline register. Inputs are DM_enable_n, DM_WEN, the EXE result used as the address, and src2 used as store data.
- Drives a req/ack memory port, stalls the pipeline until the memory completes, and presents load data to the MEM/WB register.
- Sits between the EX/MEM register outputs and the data memory.
- Enforces word alignment and a bus timeout.

Parameters:
XLEN, 32, data/address width
TIMEOUT, 16, maximum number of cycles mem_req_o stays high without mem_ack_i before the access is aborted
TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
dm_enable_n_i  in  1  active-low memory-op request from EX/MEM
dm_wen_i  in  1  active-low write select (0=store, 1=load)
addr_i  in  XLEN  byte address (EXE_DATA)
wdata_i  in  XLEN  store data (src2_DATA)
mem_req_o  out  1  memory request, level, held until ack
mem_we_o  out  1  active-high write to memory
mem_addr_o  out  XLEN  registered address
mem_wdata_o  out  XLEN  registered store data
mem_ack_i  in  1  memory completion, single-cycle pulse
mem_rdata_i  in  XLEN  read data, valid with mem_ack_i
stall_o  out  1  holds PC, IF/ID, ID/EX and EX/MEM registers
rdata_o  out  XLEN  load result to MEM/WB
rdata_valid_o  out  1  rdata_o valid (loads only)
bus_err_o  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- States: IDLE, WAIT, DONE, ERR. Encoded 2 bits.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE and counter=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - rdata_o=0, rdata_valid_o=0, bus_err_o=0.
  - stall_o is forced 0 while rst_n=0.
- Reset mid-access drops mem_req_o at that edge with no completion. The memory side tolerates a withdrawn request.
- IDLE:
  - stall_o = ~dm_enable_n_i. This is combinational so the EX/MEM register is held on the op's first cycle.
  - If dm_enable_n_i=0 and addr_i[1:0]!=0: go to ERR with no memory request.
  - If dm_enable_n_i=0 and aligned: latch addr_i, wdata_i and ~dm_wen_i into mem_addr_o, mem_wdata_o and mem_we_o. Set mem_req_o=1, clear the counter, go to WAIT.
- WAIT:
  - stall_o=1 and mem_req_o=1.
  - If mem_ack_i=1: capture mem_rdata_i into rdata_o for loads (rdata_o=0 for stores). Set rdata_valid_o=~mem_we_o, drop mem_req_o, go to DONE.
  - Else if counter==TIMEOUT-1: drop mem_req_o, go to ERR.
  - Else counter+1.
  - An ack arriving in the same cycle as timeout expiry is treated as success.
- DONE:
  - stall_o=0, so the pipeline advances on this edge and MEM/WB samples rdata_o.
  - Always returns to IDLE; it never re-triggers on the still-visible op.
  - rdata_valid_o clears on exit; rdata_o holds its value.
- ERR:
  - stall_o=0, bus_err_o=1 for exactly this cycle, rdata_o=0, rdata_valid_o=0.
  - The instruction retires with zero result; next state is IDLE.
- mem_addr_o, mem_wdata_o and mem_we_o are stable for the whole time mem_req_o=1.
- Latency:
  - An op first visible in cycle N issues its request in cycle N+1.
  - An ack in cycle N+k (k>=1) gives DONE in N+k+1.
  - Stall is high for k+1 cycles; the minimum is 2 stall cycles.
- Back-to-back memory ops: the next op is first visible in the IDLE cycle after DONE/ERR and is handled identically. No bubble is inserted beyond that.
- Misaligned check applies to both loads and stores (word accesses only).
- A spurious mem_ack_i in IDLE, DONE or ERR is ignored.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - the state enum DMC_IDLE/DMC_WAIT/DMC_DONE/DMC_ERR;
  - XLEN;
  - the DM active-low encoding constants DM_EN_ACTIVE=1'b0 and DM_WR_ACTIVE=1'b0.
- One natural sub-module: dmc_timeout_cnt (clear, enable, expiry flag at TIMEOUT-1). Everything else stays in one module.

Test Plan:
- Aligned load, addr=0x0000_0010, ack 1 cycle after req with rdata=0xDEADBEEF:
  - stall high 2 cycles, mem_we_o=0;
  - DONE shows rdata_o=0xDEADBEEF, rdata_valid_o=1, stall 0.
- Aligned store, addr=0x20, wdata=0x1234_5678, ack after 3 cycles:
  - mem_we_o=1 and addr/wdata stable while req is high;
  - stall high 4 cycles, rdata_valid_o=0.
- Misaligned load, addr=0x13:
  - no mem_req_o;
  - next cycle is ERR with bus_err_o pulse of 1 cycle, stall high 1 cycle total.
- No ack, TIMEOUT=16:
  - mem_req_o high exactly 16 cycles, then the ERR pulse;
  - an ack arriving in the 16th cycle instead gives DONE with data and no error.
- Back-to-back load then store, each acked immediately:
  - two complete sequences, each with 2 stall cycles;
  - the second req is issued 2 cycles after the first DONE (IDLE cycle, then WAIT).
- rst_n low during WAIT:
  - the next edge gives mem_req_o=0, stall_o=0, state IDLE;
  - a later ack is ignored and the next op proceeds normally.
